// File: rtl/calendar_pkg.sv
// Shared types and field limits for the time-of-day controller.
// Mode encodings, field widths and wrap values.
package calendar_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  // SET_SEC wraps back to RUN
  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button rising-edge detect with optional hold-to-repeat on the ms tick.
// REP_DLY_MS = 0 removes the repeat path entirely.
module btn_repeat
  import calendar_pkg::*;
#(
  parameter int REP_DLY_MS = 500,
  parameter int REP_PER_MS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic level,
  input  logic clr,
  output logic pulse
);

  logic prev;
  logic rise;

  // prev resets high so a button held through reset gives no edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign rise = level & ~prev;

  generate
    if (REP_DLY_MS == 0) begin : g_norep
      logic unused;
      assign unused = tick ^ clr;
      assign pulse  = rise;
    end else begin : g_rep
      localparam int CW = $clog2(REP_DLY_MS + REP_PER_MS + 1);
      localparam logic [CW-1:0] DLY = CW'(REP_DLY_MS);
      localparam logic [CW-1:0] TOP = CW'(REP_DLY_MS + REP_PER_MS);

      logic [CW-1:0] cnt;
      logic [CW-1:0] nxt;
      logic          rep;

      assign nxt = cnt + CW'(1);
      assign rep = level & tick & ((nxt == DLY) | (nxt == TOP));

      // after the first repeat the count cycles DLY..TOP
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (!level || clr)  cnt <= '0;
        else if (tick)           cnt <= (nxt == TOP) ? DLY : nxt;
      end

      assign pulse = rise | rep;
    end
  endgenerate

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day HH:MM:SS keeper with button set mode, blink hints
// and a day-carry pulse.
module clock_set_ctrl
  import calendar_pkg::*;
#(
  parameter int REP_DLY_MS = 500,
  parameter int REP_PER_MS = 100,
  parameter int BLINK_MS   = 500,
  parameter int TIMEOUT_S  = 30
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST_N,
  input  logic              MS_F,
  input  logic              S_F,
  input  logic              BTN_MODE,
  input  logic              BTN_INC,
  output logic [HOUR_W-1:0] HOUR,
  output logic [MIN_W-1:0]  MIN,
  output logic [SEC_W-1:0]  SEC,
  output logic [1:0]        MODE,
  output logic [2:0]        BLANK,
  output logic              DAY_F
);

  localparam int BW = $clog2(BLINK_MS + 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_MS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_S - 1);

  mode_t             mode, mode_n;
  logic [HOUR_W-1:0] hour, hour_n;
  logic [MIN_W-1:0]  min, min_n;
  logic [SEC_W-1:0]  sec, sec_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              phase, phase_n;
  logic [2:0]        blank, blank_n;
  logic              day, day_n;
  logic              clr;
  logic              mode_p;
  logic              inc_p;

  btn_repeat #(
    .REP_DLY_MS(0),
    .REP_PER_MS(0)
  ) u_mode (
    .clk  (SYS_CLK),
    .rst_n(SYS_RST_N),
    .tick (MS_F),
    .level(BTN_MODE),
    .clr  (1'b0),
    .pulse(mode_p)
  );

  btn_repeat #(
    .REP_DLY_MS(REP_DLY_MS),
    .REP_PER_MS(REP_PER_MS)
  ) u_inc (
    .clk  (SYS_CLK),
    .rst_n(SYS_RST_N),
    .tick (MS_F),
    .level(BTN_INC),
    .clr  (clr),
    .pulse(inc_p)
  );

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      mode  <= RUN;
      hour  <= '0;
      min   <= '0;
      sec   <= '0;
      bcnt  <= '0;
      tcnt  <= '0;
      phase <= 1'b0;
      blank <= '0;
      day   <= 1'b0;
    end else begin
      mode  <= mode_n;
      hour  <= hour_n;
      min   <= min_n;
      sec   <= sec_n;
      bcnt  <= bcnt_n;
      tcnt  <= tcnt_n;
      phase <= phase_n;
      blank <= blank_n;
      day   <= day_n;
    end
  end

  always_comb begin
    mode_n  = mode;
    hour_n  = hour;
    min_n   = min;
    sec_n   = sec;
    bcnt_n  = bcnt;
    tcnt_n  = tcnt;
    phase_n = phase;
    blank_n = '0;
    day_n   = 1'b0;
    clr     = 1'b0;

    if (MS_F) begin
      if (bcnt == B_LAST) begin
        bcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        bcnt_n  = bcnt + BW'(1);
      end
    end

    if (mode == RUN) begin
      if (S_F) begin
        if (sec != SEC_MAX) begin
          sec_n = sec + SEC_W'(1);
        end else begin
          sec_n = '0;
          if (min != MIN_MAX) begin
            min_n = min + MIN_W'(1);
          end else begin
            min_n = '0;
            if (hour != HOUR_MAX) begin
              hour_n = hour + HOUR_W'(1);
            end else begin
              hour_n = '0;
              day_n  = 1'b1;
            end
          end
        end
      end
      if (mode_p) mode_n = SET_HOUR;
    end else if (mode_p) begin
      // a mode change drops any coincident increment
      mode_n = next_mode(mode);
      tcnt_n = '0;
      clr    = (mode == SET_SEC);
    end else if (inc_p) begin
      tcnt_n  = '0;
      phase_n = 1'b0;
      unique case (mode)
        SET_HOUR: hour_n = (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
        SET_MIN:  min_n  = (min == MIN_MAX) ? '0 : min + MIN_W'(1);
        SET_SEC:  sec_n  = (sec == SEC_MAX) ? '0 : sec + SEC_W'(1);
        default:  ;
      endcase
    end else if (S_F) begin
      if (tcnt == T_LAST) begin
        mode_n = RUN;
        tcnt_n = '0;
        clr    = 1'b1;
      end else begin
        tcnt_n = tcnt + TW'(1);
      end
    end

    unique case (mode_n)
      RUN:      blank_n = 3'b000;
      SET_HOUR: blank_n = {phase_n, 2'b00};
      SET_MIN:  blank_n = {1'b0, phase_n, 1'b0};
      SET_SEC:  blank_n = {2'b00, phase_n};
    endcase
  end

  assign HOUR  = hour;
  assign MIN   = min;
  assign SEC   = sec;
  assign MODE  = mode;
  assign BLANK = blank;
  assign DAY_F = day;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized bench for clock_set_ctrl against a time-in-seconds model.
// Directed sequences pin the model with hand-computed literals.
module tb_clock_set_ctrl;

  localparam int DLY   = 500;
  localparam int PER   = 100;
  localparam int BLINK = 500;
  localparam int TO    = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ms_f = 1'b0;
  logic       s_f = 1'b0;
  logic       btn_mode = 1'b1;
  logic       btn_inc = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic [2:0] blank;
  logic       day_f;

  int checks = 0;
  int errors = 0;

  int m_h, m_m, m_s, m_mode, m_day, m_phase;
  int m_msc, m_held, m_to;
  bit m_pm, m_pi;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .REP_DLY_MS(DLY),
    .REP_PER_MS(PER),
    .BLINK_MS  (BLINK),
    .TIMEOUT_S (TO)
  ) dut (
    .SYS_CLK  (clk),
    .SYS_RST_N(rst_n),
    .MS_F     (ms_f),
    .S_F      (s_f),
    .BTN_MODE (btn_mode),
    .BTN_INC  (btn_inc),
    .HOUR     (hour),
    .MIN      (min),
    .SEC      (sec),
    .MODE     (mode),
    .BLANK    (blank),
    .DAY_F    (day_f)
  );

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0;
    m_mode = 0; m_day = 0; m_phase = 0;
    m_msc = 0; m_held = 0; m_to = 0;
    m_pm = 1'b1; m_pi = 1'b1;
  endtask

  task automatic model_step();
    bit me, ie, rep, inc, clr;
    int t;
    me = btn_mode && !m_pm;
    ie = btn_inc && !m_pi;
    m_pm = btn_mode;
    m_pi = btn_inc;
    rep = 1'b0;
    clr = 1'b0;
    m_day = 0;
    if (btn_inc) begin
      if (ms_f) begin
        m_held++;
        if (m_held >= DLY && (m_held - DLY) % PER == 0) rep = 1'b1;
      end
    end else begin
      m_held = 0;
    end
    inc = ie || rep;
    if (ms_f) begin
      m_msc++;
      if (m_msc % BLINK == 0) m_phase ^= 1;
    end
    if (m_mode == 0) begin
      if (s_f) begin
        t = m_h * 3600 + m_m * 60 + m_s + 1;
        if (t == 86400) begin
          t = 0;
          m_day = 1;
        end
        m_h = t / 3600;
        m_m = (t / 60) % 60;
        m_s = t % 60;
      end
      if (me) m_mode = 1;
    end else if (me) begin
      if (m_mode == 3) clr = 1'b1;
      m_mode = (m_mode + 1) % 4;
      m_to = 0;
    end else if (inc) begin
      m_to = 0;
      m_phase = 0;
      case (m_mode)
        1:       m_h = (m_h + 1) % 24;
        2:       m_m = (m_m + 1) % 60;
        default: m_s = (m_s + 1) % 60;
      endcase
    end else if (s_f) begin
      m_to++;
      if (m_to == TO) begin
        m_mode = 0;
        m_to = 0;
        clr = 1'b1;
      end
    end
    if (clr) m_held = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  function automatic int exp_blank();
    if (m_mode == 0) return 0;
    return m_phase << (3 - m_mode);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("hour",  int'(hour),  m_h);
    chk("min",   int'(min),   m_m);
    chk("sec",   int'(sec),   m_s);
    chk("mode",  int'(mode),  m_mode);
    chk("blank", int'(blank), exp_blank());
    chk("day_f", int'(day_f), m_day);
  endtask

  task automatic step(input bit ms, input bit sf,
                      input bit bm, input bit bi);
    ms_f = ms;
    s_f = sf;
    btn_mode = bm;
    btn_inc = bi;
    @(negedge clk);
    cmp_all();
  endtask

  task automatic press_mode();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic press_inc();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  initial begin
    bit bm, bi;
    @(negedge clk);
    repeat (3) step(0, 0, 1, 0);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 1, 0);
    chk("lit_reset_mode", int'(mode), 0);
    chk("lit_reset_time", int'({hour, min, sec}), 0);
    chk("lit_reset_blank", int'(blank), 0);
    step(0, 0, 0, 0);

    // preload 23:59:58 through the set menu
    press_mode();
    repeat (23) press_inc();
    press_mode();
    repeat (59) press_inc();
    press_mode();
    repeat (58) press_inc();
    press_mode();
    chk("lit_pre_hour", int'(hour), 23);
    chk("lit_pre_min", int'(min), 59);
    chk("lit_pre_sec", int'(sec), 58);
    chk("lit_pre_mode", int'(mode), 0);
    step(0, 1, 0, 0);
    chk("lit_sec59", int'(sec), 59);
    chk("lit_noday", int'(day_f), 0);
    step(0, 1, 0, 0);
    chk("lit_midnight", int'({hour, min, sec}), 0);
    chk("lit_day_f", int'(day_f), 1);
    step(0, 0, 0, 0);
    chk("lit_day_f_drop", int'(day_f), 0);

    // hour wrap in SET_HOUR, seconds tick frozen
    press_mode();
    repeat (22) press_inc();
    chk("lit_h22", int'(hour), 22);
    step(0, 0, 0, 1);
    chk("lit_h23", int'(hour), 23);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("lit_h0", int'(hour), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("lit_h1", int'(hour), 1);
    step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    chk("lit_frozen_h", int'(hour), 1);
    chk("lit_frozen_ms", int'({min, sec}), 0);
    chk("lit_set_hour", int'(mode), 1);

    // hold INC 1000 ms in SET_MIN: edge plus repeats at 500..1000
    press_mode();
    chk("lit_set_min", int'(mode), 2);
    repeat (499) step(1, 0, 0, 1);
    chk("lit_min_pre_rep", int'(min), 1);
    step(1, 0, 0, 1);
    chk("lit_min_rep1", int'(min), 2);
    repeat (500) step(1, 0, 0, 1);
    chk("lit_min_hold", int'(min), 7);
    step(0, 0, 0, 0);

    // timeout from SET_SEC after 30 s without buttons
    press_mode();
    repeat (29) step(0, 1, 0, 0);
    chk("lit_to_29", int'(mode), 3);
    step(0, 1, 0, 0);
    chk("lit_to_30", int'(mode), 0);
    step(0, 1, 0, 0);
    chk("lit_run_sec", int'(sec), 1);

    // mode edge beats a coincident inc edge
    press_mode();
    press_mode();
    step(0, 0, 1, 1);
    chk("lit_both_mode", int'(mode), 3);
    chk("lit_both_min", int'(min), 7);
    step(0, 0, 0, 0);

    bm = 1'b0;
    bi = 1'b0;
    repeat (20000) begin
      if ($urandom_range(299) == 0) bm = !bm;
      if ($urandom_range(399) == 0) bi = !bi;
      step($urandom_range(9) != 0, $urandom_range(19) == 0, bm, bi);
    end

    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_time", int'({hour, min, sec}), 0);
    chk("lit_async_mode", int'(mode), 0);
    chk("lit_async_blank", int'(blank), 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // blink phase on the SET_SEC field
    press_mode();
    press_mode();
    press_mode();
    repeat (499) step(1, 0, 0, 0);
    chk("lit_blink_off", int'(blank), 0);
    step(1, 0, 0, 0);
    chk("lit_blink_on", int'(blank), 1);
    repeat (500) step(1, 0, 0, 0);
    chk("lit_blink_off2", int'(blank), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
